// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the icache/dcache to pmem arbiter.
package cache_arbiter_pkg;

  localparam int S_LINE = 256;
  localparam int S_ADDR = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ICACHE = 2'd1,
    ARB_DCACHE = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

  function automatic arb_state_t serve_state(input arb_req_t r);
    return (r == REQ_D) ? ARB_DCACHE : ARB_ICACHE;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the two cache miss ports and the downstream pmem port.
interface cache_arbiter_if;
  import cache_arbiter_pkg::*;

  // Handshake: a cache's read/write strobe is its valid and is held until its
  // *_pmem_resp one-cycle pulse; pmem_read/pmem_write are held until pmem_resp.
  logic              i_pmem_read;
  logic              i_pmem_write;
  logic [S_ADDR-1:0] i_pmem_address;
  logic [S_LINE-1:0] i_pmem_wdata;
  logic              i_pmem_resp;
  logic [S_LINE-1:0] i_pmem_rdata;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [S_ADDR-1:0] d_pmem_address;
  logic [S_LINE-1:0] d_pmem_wdata;
  logic              d_pmem_resp;
  logic [S_LINE-1:0] d_pmem_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [S_ADDR-1:0] pmem_address;
  logic [S_LINE-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [S_LINE-1:0] pmem_rdata;

  // master: the arbiter, which masters the pmem port on behalf of the caches
  modport master (
    input  i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
    output i_pmem_resp, i_pmem_rdata,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_resp, d_pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    output i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
    input  i_pmem_resp, i_pmem_rdata,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_resp, d_pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );

endinterface

// File: rtl/cache_arbiter_select.sv
// Winner selection between the two pending caches.
// CACHE_ARBITER_RR_EN selects round-robin; otherwise dcache always wins ties.
module cache_arbiter_select
  import cache_arbiter_pkg::*;
(
  input  logic     i_pend,
  input  logic     d_pend,
  input  arb_req_t last_grant,
  output arb_req_t winner
);

  arb_req_t tie_winner;

`ifdef CACHE_ARBITER_RR_EN
  assign tie_winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign tie_winner        = REQ_D;
`endif

  always_comb begin
    winner = REQ_I;
    if (i_pend && d_pend) begin
      winner = tie_winner;
    end else if (d_pend) begin
      winner = REQ_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbiter granting the single pmem port to icache or dcache one line at a time.
// Build option: CACHE_ARBITER_RR_EN (round-robin tie break, see cache_arbiter_select).
module cache_arbiter
  import cache_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  cache_arbiter_if.master  bus,
  output arb_state_t       dbg_state,
  output arb_req_t         dbg_last_grant
);

  arb_state_t        state;
  arb_req_t          last_grant;
  arb_req_t          winner;
  logic              i_pend;
  logic              d_pend;
  logic              sel_write;
  logic [S_ADDR-1:0] addr_q;
  logic [S_LINE-1:0] wdata_q;
  logic              pmem_read_q;
  logic              pmem_write_q;

  // Write wins over read when a cache raises both strobes.
  assign i_pend    = bus.i_pmem_read | bus.i_pmem_write;
  assign d_pend    = bus.d_pmem_read | bus.d_pmem_write;
  assign sel_write = (winner == REQ_D) ? bus.d_pmem_write : bus.i_pmem_write;

  cache_arbiter_select u_select (
    .i_pend     (i_pend),
    .d_pend     (d_pend),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      last_grant   <= REQ_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_pend || d_pend) begin
            state        <= serve_state(winner);
            last_grant   <= winner;
            addr_q       <= (winner == REQ_D) ? bus.d_pmem_address : bus.i_pmem_address;
            wdata_q      <= (winner == REQ_D) ? bus.d_pmem_wdata : bus.i_pmem_wdata;
            pmem_write_q <= sel_write;
            pmem_read_q  <= ~sel_write;
          end
        end
        ARB_ICACHE, ARB_DCACHE: begin
          // Requester inputs are not looked at here; only pmem_resp ends the serve.
          if (bus.pmem_resp) begin
            state        <= ARB_IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        default: begin
          state        <= ARB_IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Completion is forwarded in the same cycle, and only to the owner.
  assign bus.i_pmem_resp  = (state == ARB_ICACHE) & bus.pmem_resp;
  assign bus.d_pmem_resp  = (state == ARB_DCACHE) & bus.pmem_resp;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

  assign dbg_state      = state;
  assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed plus randomized bench for cache_arbiter against a transaction-level model.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_arbiter_if bus ();
  arb_state_t dbg_state;
  arb_req_t   dbg_last_grant;

  cache_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_last_grant (dbg_last_grant)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // Outstanding request per cache, index 0 = icache, 1 = dcache.
  logic              r_rd    [2];
  logic              r_wr    [2];
  logic [S_ADDR-1:0] r_addr  [2];
  logic [S_LINE-1:0] r_wdata [2];
  arb_req_t          mdl_last;
  // Scoreboard of expected grants: {owner_is_d, is_write, address}.
  logic [S_ADDR+1:0] exp_q[$];

  function automatic bit pending(input int k);
    return r_rd[k] | r_wr[k];
  endfunction

  function automatic arb_req_t model_pick();
    if (pending(0) && !pending(1)) return REQ_I;
    if (pending(1) && !pending(0)) return REQ_D;
`ifdef CACHE_ARBITER_RR_EN
    return (mdl_last == REQ_D) ? REQ_I : REQ_D;
`else
    return REQ_D;
`endif
  endfunction

  function automatic logic [S_LINE-1:0] rand_line();
    logic [S_LINE-1:0] v;
    for (int k = 0; k < S_LINE / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- checks ----------------
  task automatic check(input string tag, input logic [S_LINE-1:0] obs, input logic [S_LINE-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int k, input logic rd, input logic wr,
                         input logic [S_ADDR-1:0] addr, input logic [S_LINE-1:0] wdata);
    r_rd[k]    = rd;
    r_wr[k]    = wr;
    r_addr[k]  = addr;
    r_wdata[k] = wdata;
  endtask

  task automatic drive_reqs();
    bus.i_pmem_read    = r_rd[0];
    bus.i_pmem_write   = r_wr[0];
    bus.i_pmem_address = r_addr[0];
    bus.i_pmem_wdata   = r_wdata[0];
    bus.d_pmem_read    = r_rd[1];
    bus.d_pmem_write   = r_wr[1];
    bus.d_pmem_address = r_addr[1];
    bus.d_pmem_wdata   = r_wdata[1];
  endtask

  task automatic scramble_reqs();
    bus.i_pmem_read    = 1'($urandom_range(0, 1));
    bus.i_pmem_write   = 1'($urandom_range(0, 1));
    bus.i_pmem_address = $urandom;
    bus.i_pmem_wdata   = rand_line();
    bus.d_pmem_read    = 1'($urandom_range(0, 1));
    bus.d_pmem_write   = 1'($urandom_range(0, 1));
    bus.d_pmem_address = $urandom;
    bus.d_pmem_wdata   = rand_line();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, S_LINE'(dbg_state), S_LINE'(ARB_IDLE));
    check1({tag, "_pmem_read"}, bus.pmem_read, 1'b0);
    check1({tag, "_pmem_write"}, bus.pmem_write, 1'b0);
    check1({tag, "_i_resp"}, bus.i_pmem_resp, 1'b0);
    check1({tag, "_d_resp"}, bus.d_pmem_resp, 1'b0);
  endtask

  // Called in an idle cycle with requests driven; returns in the cycle after the resp.
  task automatic serve_one(input int lat);
    arb_req_t          w;
    int                k;
    logic [S_ADDR+1:0] e;
    logic [S_LINE-1:0] exp_wdata;
    logic [S_LINE-1:0] rd;
    w         = model_pick();
    k         = int'(w);
    exp_q.push_back({(w == REQ_D), r_wr[k], r_addr[k]});
    exp_wdata = r_wdata[k];
    mdl_last  = w;
    e         = exp_q.pop_front();
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      scramble_reqs();
      rd             = rand_line();
      bus.pmem_rdata = rd;
      bus.pmem_resp  = (c == lat);
      #1;
      check("serve_state", S_LINE'(dbg_state), S_LINE'(e[S_ADDR+1] ? ARB_DCACHE : ARB_ICACHE));
      check1("pmem_write", bus.pmem_write, e[S_ADDR]);
      check1("pmem_read", bus.pmem_read, ~e[S_ADDR]);
      check("pmem_address", S_LINE'(bus.pmem_address), S_LINE'(e[S_ADDR-1:0]));
      check("pmem_wdata", bus.pmem_wdata, exp_wdata);
      check1("i_resp", bus.i_pmem_resp, (c == lat) && !e[S_ADDR+1]);
      check1("d_resp", bus.d_pmem_resp, (c == lat) && e[S_ADDR+1]);
      if (c == lat) begin
        check("owner_rdata", e[S_ADDR+1] ? bus.d_pmem_rdata : bus.i_pmem_rdata, rd);
      end
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    r_rd[k]       = 1'b0;
    r_wr[k]       = 1'b0;
    drive_reqs();
    #1;
    check_idle("post_resp");
    check("last_grant", S_LINE'(dbg_last_grant), S_LINE'(mdl_last));
  endtask

  task automatic serve_all();
    while (pending(0) || pending(1)) serve_one($urandom_range(1, 4));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n          = 1'b0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    for (int k = 0; k < 2; k++) set_req(k, 1'b0, 1'b0, '0, '0);
    drive_reqs();
    mdl_last = REQ_I;
    #1;
    check_idle("reset");
    check("reset_address", S_LINE'(bus.pmem_address), '0);
    check("reset_wdata", bus.pmem_wdata, '0);
    check("reset_i_rdata", bus.i_pmem_rdata, '0);
    check("reset_last_grant", S_LINE'(dbg_last_grant), S_LINE'(REQ_I));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // icache read alone, resp five cycles after grant
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    drive_reqs();
    #1;
    check_idle("t1_request_cycle");
    serve_one(5);

    // dcache write of an all-A5 line
    set_req(1, 1'b0, 1'b1, 32'h8000_0020, {32{8'hA5}});
    drive_reqs();
    serve_one(3);

    // simultaneous reads, two rounds: D then I each round
    for (int round = 0; round < 2; round++) begin
      set_req(0, 1'b1, 1'b0, $urandom, '0);
      set_req(1, 1'b1, 1'b0, $urandom, '0);
      drive_reqs();
      serve_one(2);
      check("both_first_grant", S_LINE'(dbg_last_grant), S_LINE'(REQ_D));
      serve_one(1);
      check("both_second_grant", S_LINE'(dbg_last_grant), S_LINE'(REQ_I));
    end

    // read+write together is a write
    set_req(0, 1'b1, 1'b1, 32'h0000_1000, rand_line());
    drive_reqs();
    serve_one(2);

    // stray pmem_resp while idle
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    check_idle("stray_resp");
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    check_idle("after_stray");

    // reset two cycles into a dcache read
    set_req(1, 1'b1, 1'b0, 32'h0000_2000, '0);
    drive_reqs();
    repeat (2) @(negedge clk);
    #1;
    check1("pre_reset_pmem_read", bus.pmem_read, 1'b1);
    rst_n         = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    check_idle("async_reset");
    check("async_reset_last_grant", S_LINE'(dbg_last_grant), S_LINE'(REQ_I));
    mdl_last = REQ_I;
    set_req(1, 1'b0, 1'b0, '0, '0);
    drive_reqs();
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    rst_n         = 1'b1;
    #1;
    check_idle("reset_release");
    @(negedge clk);
    #1;
    check_idle("reset_release_next");

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 2; k++) begin
        logic rd;
        logic wr;
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        set_req(k, rd, wr, $urandom, rand_line());
      end
      if (!pending(0) && !pending(1)) r_rd[$urandom_range(0, 1)] = 1'b1;
      drive_reqs();
      serve_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory port between the instruction cache and the data cache miss paths. It accepts one 256-bit line read or write at a time from either cache, latches it, and drives it to pmem. It returns pmem's response only to the requester that owns the transaction. It sits between the two `cache` instances and the memory/L2 interface.

## Interface
- `s_line`, 256: line width in bits.
- `s_addr`, 32: address width in bits.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_pmem_read`, `i_pmem_write`  in  1 each  icache request strobes.
- `i_pmem_address`  in  s_addr  icache line address.
- `i_pmem_wdata`  in  s_line  icache write line.
- `i_pmem_resp`  out  1  icache completion pulse.
- `i_pmem_rdata`  out  s_line  icache read line.
- `d_pmem_read`, `d_pmem_write`, `d_pmem_address`, `d_pmem_wdata`, `d_pmem_resp`, `d_pmem_rdata`: dcache equivalents, same widths and directions.
- `pmem_read`, `pmem_write`  out  1 each  downstream request strobes.
- `pmem_address`  out  s_addr  downstream address.
- `pmem_wdata`  out  s_line  downstream write line.
- `pmem_resp`  in  1  downstream completion.
- `pmem_rdata`  in  s_line  downstream read line.

## Operation
- FSM states are `ARB_IDLE`, `ARB_ICACHE` and `ARB_DCACHE`.
- Reset value: `ARB_IDLE`.
- A requester is pending when its read or its write strobe is high.
- If a requester asserts read and write together, the request is a write.
- In `ARB_IDLE`, if any requester is pending:
  - select a winner by the priority rule;
  - latch the winner's address, wdata and op into the request registers;
  - move to the winner's state.
- Default priority: dcache wins when both are pending.
- In a serve state:
  - `pmem_read` or `pmem_write` is driven from the latched op; `pmem_address` and `pmem_wdata` are driven from the latched registers;
  - on `pmem_resp`, pulse the owner's `*_pmem_resp` for that same cycle and return to `ARB_IDLE`.
- `i_pmem_rdata` and `d_pmem_rdata` both carry `pmem_rdata` combinationally. Only the owner's resp qualifies it.
- The non-owner's resp stays 0 at all times.
- Requester inputs are ignored while a serve state is active. Latched values hold.
- If the owner drops its request mid-transaction, the pmem transaction still completes and the owner's resp still pulses once.
- `pmem_resp` in `ARB_IDLE` is ignored; no requester resp is generated.
- `last_grant` records the last granted requester. Reset value: icache.

## Timing
- Reset values: all outputs 0, latched registers 0.
- `rst_n` low mid-transaction:
  - `pmem_read` and `pmem_write` drop to 0 immediately (asynchronously);
  - the transaction is abandoned and no resp is issued.
- Request seen in cycle N (state `ARB_IDLE`): state and latches update at the N→N+1 edge, and `pmem_read`/`pmem_write` are high from cycle N+1. Grant overhead is 1 cycle.
- `pmem_resp` in cycle M produces the requester resp in cycle M (0-cycle forward). The state is `ARB_IDLE` in M+1.
- A new grant is possible at the M+1→M+2 edge.
- `pmem_read` and `pmem_write` remain high continuously from grant through the resp cycle. They deassert in M+1.
- Requesters must hold their strobes until their resp. A strobe still high in M+1 is treated as a new request.

## Configuration
- `CACHE_ARBITER_RR_EN` defined: round-robin priority. When both requesters are pending in `ARB_IDLE`, the one not equal to `last_grant` wins.
- `CACHE_ARBITER_RR_EN` undefined: fixed dcache-first priority. `last_grant` is still maintained but is unused.

## Structure
- Package `cache_arbiter_pkg` holds:
  - `arb_state_t` enum {`ARB_IDLE`, `ARB_ICACHE`, `ARB_DCACHE`};
  - `arb_req_t` enum {`REQ_I`, `REQ_D`};
  - line and address width constants shared with `cache`.
- Sub-module `cache_arbiter_select`: combinational winner selection from the two pending bits and `last_grant`. The configuration macro is confined to this module.
- The top level holds the FSM, request latches and output muxing.

## Test plan
- icache read at 0x0000_0040 alone, pmem resp after 5 cycles: `pmem_read` high in cycles 1–5 with address 0x40; `i_pmem_resp` pulses once in cycle 5; `d_pmem_resp` stays 0.
- dcache write at 0x8000_0020 with wdata all-0xA5: `pmem_write` high with latched wdata; `d_pmem_resp` pulses; the arbiter then returns to idle.
- icache read and dcache read pending in the same cycle, fixed priority: dcache is served first and icache second. Two grants total, each with its own single resp.
- Same simultaneous requests, repeated twice, with `CACHE_ARBITER_RR_EN` defined: grant order is D, I, D, I (`last_grant` resets to icache).
- `rst_n` pulled low two cycles into a dcache read: `pmem_read` is 0 immediately, no resp follows, and the state is idle after release.
- A stray `pmem_resp` while idle, and icache address changed mid-transaction: no resp in the idle case, and `pmem_address` keeps the originally latched value.
